// File: rtl/fish_sprite_ctrl.sv
// fish_sprite_ctrl: fish sprite ROM addressing, key-colour masked 2-stage pixel pipeline, and swim/catch/respawn FSM (ins: scan x/y, frame_tick, hook, rom_color; outs: rom_row/col, fish_on/rgb, caught, catch_pulse, fish_x/y)
module fish_sprite_ctrl #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480,
  parameter int SPR_W = 32,
  parameter int SPR_H = 16,
  parameter int X_START = 0,
  parameter int Y_START = 300,
  parameter int SPEED = 2,
  parameter logic [11:0] KEY_COLOR = 12'h0F0,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic [9:0]  hook_x,
  input  logic [9:0]  hook_y,
  input  logic        hook_active,
  output logic [3:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] rom_color,
  output logic        fish_on,
  output logic [11:0] rgb,
  output logic        caught,
  output logic        catch_pulse,
  output logic [9:0]  fish_x,
  output logic [9:0]  fish_y
);
  localparam int CW = $clog2(PAUSE_FRAMES) + 1;
  typedef enum logic [1:0] {SWIM, CAUGHT, RESPAWN} state_t;
  state_t state, state_n;
  logic right, right_n, vis_d, fish_on_n, hit, wall_r, wall_l, mv, pulse_n;
  logic [9:0] fish_x_n, fish_y_n;
  logic [10:0] dx, dy, hx, hy;
  logic [CW-1:0] cnt, cnt_n;
  assign dx = {1'b0, x} - {1'b0, fish_x};
  assign dy = {1'b0, y} - {1'b0, fish_y};
  assign hx = {1'b0, hook_x} - {1'b0, fish_x};
  assign hy = {1'b0, hook_y} - {1'b0, fish_y};
  assign hit = hook_active && hx < 11'(SPR_W) && hy < 11'(SPR_H);
  assign wall_r = {1'b0, fish_x} + 11'(SPEED) >= 11'(H_MAX - SPR_W);
  assign wall_l = fish_x <= 10'(SPEED);
  assign mv = state == SWIM && frame_tick && !hit;
  assign rom_row = dy[3:0];
  assign rom_col = right ? dx[4:0] : 5'(SPR_W - 1) - dx[4:0];
  assign caught = state == CAUGHT;
  assign fish_on_n = vis_d && rom_color != KEY_COLOR;
  always_ff @(posedge clk)
    state <= reset ? SWIM : state_n;
  always_comb
    state_n = state == SWIM ? (frame_tick && hit ? CAUGHT : SWIM)
            : state == CAUGHT ? (frame_tick && cnt == CW'(PAUSE_FRAMES - 1) ? RESPAWN : CAUGHT)
            : SWIM;
  always_comb begin
    fish_x_n = state == RESPAWN ? 10'(X_START)
             : !mv ? fish_x
             : right ? (wall_r ? 10'(H_MAX - SPR_W) : fish_x + 10'(SPEED))
             : (wall_l ? 10'd0 : fish_x - 10'(SPEED));
    fish_y_n = state == RESPAWN ? 10'(Y_START) : fish_y;
    right_n = state == RESPAWN ? 1'b1 : mv ? (right ? !wall_r : wall_l) : right;
    pulse_n = state == SWIM && frame_tick && hit;
    cnt_n = pulse_n ? '0 : state == CAUGHT && frame_tick ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fish_x <= 10'(X_START);
      fish_y <= 10'(Y_START);
      right <= 1'b1;
      cnt <= '0;
      catch_pulse <= 1'b0;
      vis_d <= 1'b0;
      fish_on <= 1'b0;
      rgb <= '0;
    end else begin
      fish_x <= fish_x_n;
      fish_y <= fish_y_n;
      right <= right_n;
      cnt <= cnt_n;
      catch_pulse <= pulse_n;
      vis_d <= dx < 11'(SPR_W) && dy < 11'(SPR_H) && video_on && state != RESPAWN;
      fish_on <= fish_on_n;
      rgb <= fish_on_n ? rom_color : '0;
    end
  end
endmodule

// File: tb/tb_fish_sprite_ctrl.sv
// tb_fish_sprite_ctrl: randomized scoreboard bench for fish_sprite_ctrl against a behavioural fish model
module tb_fish_sprite_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, video_on, frame_tick, hook_active, fish_on, caught, catch_pulse;
  logic [9:0] x, y, hook_x, hook_y, fish_x, fish_y;
  logic [3:0] rom_row;
  logic [4:0] rom_col;
  logic [11:0] rom_color = '0, rgb;
  fish_sprite_ctrl dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .frame_tick(frame_tick),
    .hook_x(hook_x), .hook_y(hook_y), .hook_active(hook_active), .rom_row(rom_row),
    .rom_col(rom_col), .rom_color(rom_color), .fish_on(fish_on), .rgb(rgb), .caught(caught),
    .catch_pulse(catch_pulse), .fish_x(fish_x), .fish_y(fish_y)
  );
  function automatic logic [11:0] rom_f(int r, int c);
    if (r == 3 && c == 5) return 12'h888;
    if (c == 13) return 12'h0F0;
    return 12'(32'h020 | (r << 8) | c);
  endfunction
  always @(posedge clk) rom_color <= rom_f(int'(rom_row), int'(rom_col));
  typedef struct {int due; bit on; logic [11:0] c;} pix_t;
  typedef struct {int due; int fx; int fy; bit cg; bit pl;} st_t;
  pix_t pq[$];
  st_t sq[$];
  int cyc = 0, errs = 0, checks = 0;
  int mx = 0, my = 300, pause = 0;
  bit mright = 1, mcaught = 0, mresp = 0, hook_rand = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  initial forever begin
    pix_t p;
    st_t s;
    @(posedge clk);
    cyc++;
    #1;
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      p = pq.pop_front();
      chk("fish_on", int'(fish_on), int'(p.on));
      chk("rgb", int'(rgb), int'(p.c));
    end
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      s = sq.pop_front();
      chk("fish_x", int'(fish_x), s.fx);
      chk("fish_y", int'(fish_y), s.fy);
      chk("caught", int'(caught), int'(s.cg));
      chk("catch_pulse", int'(catch_pulse), int'(s.pl));
    end
  end
  task automatic cycle();
    int dx, dy, col;
    bit vis, pl, op;
    logic [11:0] c;
    dx = int'(x) - mx;
    dy = int'(y) - my;
    vis = video_on && dx >= 0 && dx < 32 && dy >= 0 && dy < 16 && !mresp && !reset;
    col = mright ? dx : 31 - dx;
    c = vis ? rom_f(dy, col) : 12'h0;
    op = vis && c != 12'h0F0;
    if (vis) begin
      #1;
      chk("rom_row", int'(rom_row), dy);
      chk("rom_col", int'(rom_col), col);
    end
    if (reset)
      foreach (pq[i]) if (pq[i].due == cyc + 1) begin pq[i].on = 0; pq[i].c = 0; end
    pq.push_back('{cyc + 2, op, op ? c : 12'h0});
    pl = 0;
    if (reset) begin
      mx = 0; my = 300; mright = 1; mcaught = 0; mresp = 0; pause = 0;
    end else if (mresp) begin
      mx = 0; my = 300; mright = 1; mresp = 0;
    end else if (mcaught) begin
      if (frame_tick) begin
        pause++;
        if (pause == 60) begin mcaught = 0; mresp = 1; end
      end
    end else if (frame_tick) begin
      if (hook_active && int'(hook_x) >= mx && int'(hook_x) < mx + 32 && int'(hook_y) >= my && int'(hook_y) < my + 16) begin
        mcaught = 1; pause = 0; pl = 1;
      end else if (mright) begin
        if (mx + 2 >= 608) begin mx = 608; mright = 0; end else mx += 2;
      end else begin
        if (mx <= 2) begin mx = 0; mright = 1; end else mx -= 2;
      end
    end
    sq.push_back('{cyc + 1, mx, my, mcaught, pl});
    @(negedge clk);
  endtask
  function automatic logic [9:0] clampx(int v);
    return 10'(v < 0 ? 0 : v > 639 ? 639 : v);
  endfunction
  task automatic rand_pix();
    x = clampx(mx - 4 + int'($urandom_range(0, 40)));
    y = clampx(my - 2 + int'($urandom_range(0, 19)));
    video_on = $urandom_range(0, 7) != 0;
    if (hook_rand) begin
      hook_x = clampx(mx - 5 + int'($urandom_range(0, 45)));
      hook_y = clampx(my - 3 + int'($urandom_range(0, 22)));
    end
  endtask
  task automatic ticks(int n);
    repeat (n) begin
      frame_tick = 1; rand_pix(); cycle();
      frame_tick = 0; rand_pix(); cycle();
    end
  endtask
  initial begin
    reset = 1; video_on = 0; frame_tick = 0; hook_active = 0;
    x = 0; y = 0; hook_x = 0; hook_y = 0;
    @(negedge clk);
    repeat (3) cycle();
    reset = 0;
    x = 5; y = 303; video_on = 1; cycle();
    x = 13; cycle();
    x = 32; cycle();
    repeat (100) begin rand_pix(); cycle(); end
    ticks(304);
    ticks(1);
    x = 606; y = 300; video_on = 1; cycle();
    ticks(283);
    hook_x = 50; hook_y = 305; hook_active = 1; frame_tick = 1; rand_pix(); cycle();
    frame_tick = 0; rand_pix(); cycle();
    hook_rand = 1;
    ticks(59);
    hook_rand = 0;
    frame_tick = 1; x = 45; y = 305; video_on = 1; cycle();
    cycle();
    frame_tick = 0; hook_active = 0;
    repeat (4) begin rand_pix(); cycle(); end
    ticks(303);
    hook_x = 610; hook_y = 305; hook_active = 1; ticks(1);
    hook_active = 0;
    ticks(5);
    reset = 1; rand_pix(); cycle();
    reset = 0; rand_pix(); cycle();
    ticks(3);
    hook_rand = 1;
    repeat (600) begin
      frame_tick = $urandom_range(0, 3) == 0;
      hook_active = $urandom_range(0, 1) == 1;
      reset = $urandom_range(0, 199) == 0;
      rand_pix();
      cycle();
    end
    reset = 0; frame_tick = 0; video_on = 0;
    repeat (4) cycle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
